// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: MSB-first bit-serial compare reporting eq/gt/lt and bits examined
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             msb_signed,
  output logic             busy,
  output logic             done,
  output logic             AeqB,
  output logic             AgtB,
  output logic             AltB,
  output logic [CW-1:0]    bits_used
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;
  stateType state, stateNext;
  logic [WIDTH-1:0] capA, capB, capANext, capBNext;
  logic capSigned, capSignedNext;
  logic busyNext, doneNext, eqNext, gtNext, ltNext;
  logic [CW-1:0] bitsNext;
  logic accept, diff, aGreater;
  assign accept = start && state != RUN;
  assign diff = capA[WIDTH-1] ^ capB[WIDTH-1];
  assign aGreater = (capSigned && bits_used == '0) ? capB[WIDTH-1] : capA[WIDTH-1];
  always_comb begin
    stateNext = state;
    capANext = capA;
    capBNext = capB;
    capSignedNext = capSigned;
    busyNext = busy;
    doneNext = 1'b0;
    eqNext = AeqB;
    gtNext = AgtB;
    ltNext = AltB;
    bitsNext = bits_used;
    if (accept) begin
      capANext = A;
      capBNext = B;
      capSignedNext = msb_signed;
      eqNext = 1'b0;
      gtNext = 1'b0;
      ltNext = 1'b0;
      bitsNext = '0;
      busyNext = 1'b1;
      stateNext = RUN;
    end else if (state == RUN) begin
      bitsNext = bits_used + CW'(1);
      capANext = capA << 1;
      capBNext = capB << 1;
      if (diff || bits_used == CW'(WIDTH - 1)) begin
        eqNext = !diff;
        gtNext = diff && aGreater;
        ltNext = diff && !aGreater;
        doneNext = 1'b1;
        busyNext = 1'b0;
        stateNext = DONE;
      end
    end else if (state == DONE) begin
      stateNext = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      capA <= '0;
      capB <= '0;
      capSigned <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      AeqB <= 1'b0;
      AgtB <= 1'b0;
      AltB <= 1'b0;
      bits_used <= '0;
    end else begin
      state <= stateNext;
      capA <= capANext;
      capB <= capBNext;
      capSigned <= capSignedNext;
      busy <= busyNext;
      done <= doneNext;
      AeqB <= eqNext;
      AgtB <= gtNext;
      AltB <= ltNext;
      bits_used <= bitsNext;
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: table vectors, corner sequences and random compares against an arithmetic model
module tb_serial_magnitude_comparator;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);
  logic clk = 1'b0;
  logic rst, start, msb_signed;
  logic [W-1:0] A, B;
  logic busy, done, AeqB, AgtB, AltB;
  logic [CW-1:0] bits_used;
  int checks = 0;
  int errors = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .msb_signed(msb_signed),
    .busy(busy), .done(done), .AeqB(AeqB), .AgtB(AgtB), .AltB(AltB), .bits_used(bits_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;
    logic eq;
    logic gt;
    logic lt;
    int bits;
  } vecT;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic eq, output logic gt, output logic lt, output int bits);
    logic [W-1:0] x;
    logic found;
    x = a ^ b;
    eq = (a == b);
    gt = s ? ($signed(a) > $signed(b)) : (a > b);
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    bits = W;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--)
      if (!found && x[i]) begin
        bits = W - i;
        found = 1'b1;
      end
  endfunction

  // Called on a negedge; leaves us on the negedge right after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start = 1'b1;
    A = a;
    B = b;
    msb_signed = s;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("flags_clear_while_busy", {AeqB, AgtB, AltB}, 0);
  endtask

  task automatic waitDone(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < W + 4) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic expectResult(input string name, input logic eq, input logic gt, input logic lt,
                              input int bits, input int lat);
    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_eq"}, AeqB, eq);
    check({name, "_gt"}, AgtB, gt);
    check({name, "_lt"}, AltB, lt);
    check({name, "_bits"}, bits_used, bits);
    check({name, "_latency"}, lat, bits);
  endtask

  initial begin
    vecT vecs[6];
    int lat, mb;
    logic me, mg, ml;
    logic [W-1:0] ra, rb;
    logic rs;
    vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[4] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 8};
    vecs[5] = '{8'hF0, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    msb_signed = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_flags", {AeqB, AgtB, AltB}, 0);
    check("reset_bits", bits_used, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      launch(vecs[i].a, vecs[i].b, vecs[i].s);
      waitDone(0, lat);
      expectResult($sformatf("vec%0d", i), vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].bits, lat);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_hold", i), {AeqB, AgtB, AltB, 4'(bits_used)},
            {vecs[i].eq, vecs[i].gt, vecs[i].lt, 4'(vecs[i].bits)});
    end

    // Inputs and start are ignored mid-compare.
    @(negedge clk);
    launch(8'h01, 8'h02, 1'b0);
    A = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("iso_busy", busy, 1);
    waitDone(1, lat);
    expectResult("iso", 1'b0, 1'b0, 1'b1, 7, lat);

    // Reset in the third RUN cycle discards the compare.
    @(negedge clk);
    launch(8'h5A, 8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_flags", {AeqB, AgtB, AltB}, 0);
    check("midrst_bits", bits_used, 0);
    launch(8'h00, 8'h00, 1'b0);
    waitDone(0, lat);
    expectResult("postrst", 1'b1, 1'b0, 1'b0, 8, lat);

    // Start during the done cycle is accepted without an idle gap.
    @(negedge clk);
    launch(8'h80, 8'h7F, 1'b0);
    waitDone(0, lat);
    expectResult("b2b_first", 1'b0, 1'b1, 1'b0, 1, lat);
    launch(8'h03, 8'h01, 1'b0);
    check("b2b_done_drop", done, 0);
    waitDone(0, lat);
    expectResult("b2b_second", 1'b0, 1'b1, 1'b0, 7, lat);

    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      rs = 1'($urandom);
      model(ra, rb, rs, me, mg, ml, mb);
      @(negedge clk);
      launch(ra, rb, rs);
      waitDone(0, lat);
      expectResult($sformatf("rnd%0d", i), me, mg, ml, mb, lat);
      check($sformatf("rnd%0d_onehot", i), AeqB + AgtB + AltB, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Bit-serial magnitude comparator. It takes two WIDTH-bit operands on a start pulse and walks them one bit per clock, starting at the MSB and moving toward the LSB.
- It stops at the first differing bit and reports equal, greater or less on the same three flags used by the combinational ripple comparators.
- It is the MSB-first, clocked counterpart of the LSB-to-MSB cascade chain. It is used where the area of a full-width compare is not justified.

Parameters:
- WIDTH, 8, operand width in bits (>= 1).
- CW, $clog2(WIDTH+1), width of the bits_used counter (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new compare; sampled only when busy=0.
- A  input  WIDTH  operand A; captured on an accepted start.
- B  input  WIDTH  operand B; captured on an accepted start.
- msb_signed  input  1  1 = two's-complement compare, 0 = unsigned; captured on an accepted start.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse; the result flags are valid.
- AeqB  output  1  A == B.
- AgtB  output  1  A > B.
- AltB  output  1  A < B.
- bits_used  output  CW  number of bit positions examined for the last result (1..WIDTH).

Behaviour:
- Clock and reset
  - Single clock. Reset is synchronous and active-high. All outputs are registered.
  - rst=1 at any edge, including mid-compare: state <- IDLE; busy, done, AeqB, AgtB, AltB <- 0; bits_used <- 0. Any in-flight compare is discarded.
- States: IDLE, RUN, DONE.
- IDLE (busy=0, done=0, flags hold the last result)
  - If start=1: capture A, B and msb_signed into internal registers.
  - Set idx <- WIDTH-1 and clear AeqB, AgtB, AltB and bits_used.
  - Set busy <- 1 and go to RUN.
- RUN (busy=1)
  - Each edge examines captured bit idx and increments bits_used.
  - Bits differ, idx = WIDTH-1, msb_signed=1: A bit 1 sets AltB, else AgtB.
  - Bits differ, all other cases: A bit 1 sets AgtB, else AltB.
  - After a difference: done <- 1, busy <- 0, go to DONE.
  - Bits equal and idx = 0: AeqB <- 1, done <- 1, busy <- 0, go to DONE.
  - Bits equal and idx > 0: idx <- idx-1, stay in RUN.
  - start and the A/B/msb_signed inputs are ignored while in RUN.
- DONE (done=1 for exactly one cycle)
  - If start=1: accept a new compare exactly as from IDLE (back-to-back). done drops next cycle.
  - Else: go to IDLE, done <- 0.
- Timing
  - Latency: start accepted at edge 0; done=1 in the cycle following edge k, where k = bits_used (1..WIDTH).
  - Worst case is WIDTH cycles from the start edge; throughput is one compare per WIDTH+1 cycles.
- Output invariants
  - Exactly one of AeqB/AgtB/AltB is 1 whenever done=1.
  - Flags and bits_used hold their value after done until the next accepted start clears them.
  - All three flags are 0 while busy=1 and after reset.
- Signed rule: only the captured MSB is treated as the sign. Lower bits compare as unsigned once the MSBs match, which is correct for two's complement.
- WIDTH=1: the single bit is the MSB, so the msb_signed rule applies; bits_used is always 1.
- start and rst in the same cycle: rst wins.

Test Plan:
- Equal operands: WIDTH=8, A=8'h5A, B=8'h5A, msb_signed=0, start pulse -> done in the 8th cycle after the start edge; AeqB=1, AgtB=0, AltB=0, bits_used=8.
- MSB difference, unsigned then signed:
  - A=8'h80, B=8'h7F, msb_signed=0 -> AgtB=1, bits_used=1, done one cycle after start.
  - Same operands with msb_signed=1 -> AltB=1, bits_used=1.
- LSB-only difference: A=8'h12, B=8'h13, msb_signed=0 -> AltB=1, bits_used=8. Repeat with msb_signed=1 -> AltB=1.
- Negative vs negative: A=8'hF0 (-16), B=8'hE0 (-32), msb_signed=1 -> AgtB=1, bits_used=4.
- Input isolation: start with A=8'h01, B=8'h02; during RUN change A to 8'hFF and pulse start -> result AltB=1 from the original operands; the extra start is ignored; busy stays 1 until done.
- Reset and back-to-back:
  - Assert rst for 1 cycle at the 3rd RUN cycle -> next cycle busy=0, done=0, all flags 0, bits_used=0. A following start of A=B=8'h00 gives AeqB=1.
  - Assert start in the done cycle with A=8'h03, B=8'h01 -> second compare accepted with no idle gap; result AgtB=1, bits_used=7.
